heart_rhythm_analyzer: RTL



---
 rtl/aed_pkg.sv | 26 ++
 rtl/beat_edge_detect.sv | 24 ++
 rtl/heart_rhythm_analyzer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/aed_pkg.sv
// Shared types and default timing constants for the AED controller and its
// rhythm analyzer front end.
package aed_pkg;

    // Rhythm analyzer tracking state.
    typedef enum logic [1:0] {
        NO_PULSE   = 2'd0,
        FIRST_BEAT = 2'd1,
        TRACKING   = 2'd2
    } rhythm_state_t;

    // AED controller top-level state.
    typedef enum logic [2:0] {
        AED_IDLE    = 3'd0,
        AED_ANALYZE = 3'd1,
        AED_CHARGE  = 3'd2,
        AED_SHOCK   = 3'd3,
        AED_CPR     = 3'd4
    } aed_state_t;

    // Cycles without a beat before the pulse is declared lost.
    localparam int TIMEOUT_CYC = 2000;
    // Refractory window after an accepted beat (T-wave rejection).
    localparam int REFRACT_CYC = 10;

endpackage

// File: rtl/beat_edge_detect.sv
// Rising-edge detector for the raw sensor beat level. The history register
// resets high so a level held high across reset is not seen as a beat.
module beat_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic beat,
    output logic beat_event
);

    logic beat_q;

    // Previous beat level, synchronous active-low reset to 1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n)
            beat_q <= 1'b1;
        else
            beat_q <= beat;
    end

    assign beat_event = beat & ~beat_q;

endmodule

// File: rtl/heart_rhythm_analyzer.sv
// Beat-interval measurement and rhythm classification. Produces the
// heartbeat-present (H) and regular-rhythm (R) flags for the AED controller.
// Build option: define HRA_REFRACTORY_EN to ignore beats that arrive within
// REFRACT_CYC cycles of the previous accepted beat.
module heart_rhythm_analyzer #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = aed_pkg::TIMEOUT_CYC,
    parameter int TOL_SHIFT   = 3,
    parameter int REG_BEATS   = 3,
    parameter int REFRACT_CYC = aed_pkg::REFRACT_CYC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             beat,
    output logic             H,
    output logic             R,
    output logic [CNT_W-1:0] interval,
    output logic             interval_valid
);

    localparam int                 MATCH_W   = $clog2(REG_BEATS + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TIMEOUT_CYC);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(REG_BEATS);

    aed_pkg::rhythm_state_t state, state_nx;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   prev, prev_nx;
    logic [CNT_W-1:0]   interval_nx;
    logic [CNT_W-1:0]   diff;
    logic [CNT_W-1:0]   tol;
    logic [MATCH_W-1:0] match, match_nx;
    logic               h_nx, r_nx, valid_nx;
    logic               edge_evt;
    logic               accept;
    logic               timeout;

    beat_edge_detect u_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .beat       (beat),
        .beat_event (edge_evt)
    );

`ifdef HRA_REFRACTORY_EN
    // Beats too soon after an accepted beat are treated as T-wave echoes.
    assign accept = edge_evt &
                    ~((state != aed_pkg::NO_PULSE) && (cnt < CNT_W'(REFRACT_CYC)));
`else
    assign accept = edge_evt;
    logic unused_refract;
    assign unused_refract = ^CNT_W'(REFRACT_CYC);
`endif

    // A beat in the same cycle as saturation wins and is measured normally.
    assign timeout = (cnt == CNT_MAX) && !accept;
    assign diff    = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
    assign tol     = prev >> TOL_SHIFT;

    // Cycles since the last accepted beat, saturating at the timeout value.
    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else if (accept)
            cnt <= CNT_W'(1);
        else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
    end

    // Next-state, interval capture and consistency tracking.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nx    = state;
        prev_nx     = prev;
        match_nx    = match;
        interval_nx = interval;
        valid_nx    = 1'b0;

        unique case (state)
            aed_pkg::NO_PULSE: begin
                if (accept)
                    state_nx = aed_pkg::FIRST_BEAT;
            end
            aed_pkg::FIRST_BEAT: begin
                if (accept) begin
                    interval_nx = cnt;
                    prev_nx     = cnt;
                    valid_nx    = 1'b1;
                    match_nx    = '0;
                    state_nx    = aed_pkg::TRACKING;
                end else if (timeout) begin
                    state_nx = aed_pkg::NO_PULSE;
                end
            end
            aed_pkg::TRACKING: begin
                if (accept) begin
                    if (diff <= tol)
                        match_nx = (match == MATCH_MAX) ? match : match + MATCH_W'(1);
                    else
                        match_nx = '0;
                    interval_nx = cnt;
                    prev_nx     = cnt;
                    valid_nx    = 1'b1;
                end else if (timeout) begin
                    state_nx = aed_pkg::NO_PULSE;
                    match_nx = '0;
                end
            end
            default: begin
                state_nx = aed_pkg::NO_PULSE;
                match_nx = '0;
            end
        endcase

        h_nx = (state_nx != aed_pkg::NO_PULSE);
        r_nx = (state_nx == aed_pkg::TRACKING) && (match_nx == MATCH_MAX);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= aed_pkg::NO_PULSE;
            prev           <= '0;
            match          <= '0;
            interval       <= '0;
            interval_valid <= 1'b0;
            H              <= 1'b0;
            R              <= 1'b0;
        end else begin
            state          <= state_nx;
            prev           <= prev_nx;
            match          <= match_nx;
            interval       <= interval_nx;
            interval_valid <= valid_nx;
            H              <= h_nx;
            R              <= r_nx;
        end
    end

endmodule
